// File: rtl/dt_pkg.sv
// Shared types and helpers for the two-pass chamfer distance-transform engine.
// Neighbour offsets take the image width as an argument so one package serves every size.
package dt_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD,
        S_FWD_RD,
        S_FWD_NB,
        S_FWD_WR,
        S_BWD_RD,
        S_BWD_NB,
        S_BWD_WR,
        S_FIN
    } dt_state_e;

    function automatic logic [2:0] nb_count(input logic mode);
        return mode ? 3'd2 : 3'd4;
    endfunction

    // Forward mask: chessboard NW, N, NE, W; city-block N, W.
    function automatic int fwd_offset(input int img_w, input logic mode, input logic [1:0] idx);
        int off;
        if (!mode) begin
            case (idx)
                2'd0:    off = -img_w - 1;
                2'd1:    off = -img_w;
                2'd2:    off = -img_w + 1;
                default: off = -1;
            endcase
        end else begin
            off = (idx == 2'd0) ? -img_w : -1;
        end
        return off;
    endfunction

    // Backward mask is the point mirror of the forward one, visited in reverse order:
    // chessboard E, SW, S, SE; city-block E, S.
    function automatic int nb_offset(input int img_w, input logic bwd, input logic mode,
                                     input logic [1:0] idx);
        logic [1:0] last;
        last = 2'(nb_count(mode) - 3'd1);
        return bwd ? -fwd_offset(img_w, mode, last - idx) : fwd_offset(img_w, mode, idx);
    endfunction

    // v+1 clamped to 2^dw-1 (dw <= 31).
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned dw);
        logic [32:0] s;
        logic [32:0] lim;
        s   = {1'b0, v} + 33'd1;
        lim = (33'd1 << dw) - 33'd1;
        return (s > lim) ? lim[31:0] : s[31:0];
    endfunction

endpackage

// File: rtl/dt_param_addr_gen.sv
// Row/column walker over the interior pixels; emits the RAM address of the current
// pixel or of one of its mask neighbours, plus first/last-interior flags.
module dt_addr_gen
    import dt_pkg::*;
#(
    parameter int IMG_W = 128,
    parameter int IMG_H = 128,
    parameter int RA_W  = 14
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            init,
    input  logic            step_fwd,
    input  logic            step_bwd,
    input  logic            use_nb,
    input  logic            bwd,
    input  logic            mode,
    input  logic [1:0]      nb_idx,
    output logic [RA_W-1:0] addr,
    output logic            is_first,
    output logic            is_last
);
    localparam int RW = $clog2(IMG_H);
    localparam int CW = $clog2(IMG_W);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 2);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 2);

    logic [RW-1:0]   row_q, row_d;
    logic [CW-1:0]   col_q, col_d;
    logic [RA_W-1:0] base;
    logic [RA_W-1:0] off;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (init) begin
            row_d = RW'(1);
            col_d = CW'(1);
        end else if (step_fwd) begin
            if (col_q == COL_LAST) begin
                col_d = CW'(1);
                row_d = row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end else if (step_bwd) begin
            if (col_q == CW'(1)) begin
                col_d = COL_LAST;
                row_d = row_q - RW'(1);
            end else begin
                col_d = col_q - CW'(1);
            end
        end
    end

    always_comb begin
        base     = RA_W'(32'(row_q) * 32'(IMG_W) + 32'(col_q));
        off      = use_nb ? RA_W'(nb_offset(IMG_W, bwd, mode, nb_idx)) : '0;
        addr     = base + off;
        is_first = (row_q == RW'(1)) && (col_q == CW'(1));
        is_last  = (row_q == ROW_LAST) && (col_q == COL_LAST);
    end

endmodule

// File: rtl/dt_param.sv
// Two-pass chamfer distance transform: unpacks the sti image into res, then runs
// forward and backward raster passes in place with saturating distances.
module dt_param
    import dt_pkg::*;
#(
    parameter int IMG_W  = 128,
    parameter int IMG_H  = 128,
    parameter int WORD_W = 16,
    parameter int DIST_W = 8,
    localparam int NPIX  = IMG_W * IMG_H,
    localparam int NWORD = NPIX / WORD_W,
    localparam int RA_W  = $clog2(NPIX),
    localparam int SA_W  = (NWORD > 1) ? $clog2(NWORD) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    output logic              busy,
    output logic              done,
    output logic              sti_rd,
    output logic [SA_W-1:0]   sti_addr,
    input  logic [WORD_W-1:0] sti_di,
    output logic              res_rd,
    output logic              res_wr,
    output logic [RA_W-1:0]   res_addr,
    output logic [DIST_W-1:0] res_do,
    input  logic [DIST_W-1:0] res_di
);
    localparam int BC_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [BC_W-1:0] BC_LAST  = BC_W'(WORD_W - 1);
    localparam logic [RA_W-1:0] PIX_LAST = RA_W'(NPIX - 1);

    dt_state_e         state_q, state_d;
    logic              mode_q, mode_d;
    logic              lprime_q, lprime_d;
    logic              rdv_q, rdv_d;
    logic [RA_W-1:0]   pix_q, pix_d;
    logic [SA_W-1:0]   wa_q, wa_d;
    logic [BC_W-1:0]   bc_q, bc_d;
    logic [WORD_W-1:0] sh_q, sh_d;
    logic [1:0]        nb_q, nb_d;
    logic [DIST_W-1:0] min_q, min_d;
    logic [DIST_W-1:0] self_q, self_d;
    logic [DIST_W-1:0] res_do_q;

    logic              ag_init, ag_fwd, ag_bwd, ag_first, ag_last;
    logic [RA_W-1:0]   ag_addr;
    logic              in_nb, in_bwd;
    logic [1:0]        nb_last;
    logic [WORD_W-1:0] cur_word;
    logic [DIST_W-1:0] nb_min, fwd_val, bwd_val;

    dt_addr_gen #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .RA_W  (RA_W)
    ) u_addr_gen (
        .clk      (clk),
        .reset    (reset),
        .init     (ag_init),
        .step_fwd (ag_fwd),
        .step_bwd (ag_bwd),
        .use_nb   (in_nb),
        .bwd      (in_bwd),
        .mode     (mode_q),
        .nb_idx   (nb_q),
        .addr     (ag_addr),
        .is_first (ag_first),
        .is_last  (ag_last)
    );

    // The first pixel of each word comes straight off sti_di; the rest from the shifter.
    always_comb begin
        cur_word = (bc_q == '0) ? sti_di : sh_q;
        nb_last  = 2'(nb_count(mode_q) - 3'd1);
        nb_min   = (res_di < min_q) ? res_di : min_q;
        fwd_val  = DIST_W'(sat_inc(32'(nb_min), DIST_W));
        bwd_val  = (self_q < fwd_val) ? self_q : fwd_val;
        in_nb    = (state_q == S_FWD_NB) || (state_q == S_BWD_NB);
        in_bwd   = (state_q == S_BWD_RD) || (state_q == S_BWD_NB) || (state_q == S_BWD_WR);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            mode_q   <= 1'b0;
            lprime_q <= 1'b0;
            rdv_q    <= 1'b0;
            pix_q    <= '0;
            wa_q     <= '0;
            bc_q     <= '0;
            sh_q     <= '0;
            nb_q     <= '0;
            min_q    <= '0;
            self_q   <= '0;
            res_do_q <= '0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            lprime_q <= lprime_d;
            rdv_q    <= rdv_d;
            pix_q    <= pix_d;
            wa_q     <= wa_d;
            bc_q     <= bc_d;
            sh_q     <= sh_d;
            nb_q     <= nb_d;
            min_q    <= min_d;
            self_q   <= self_d;
            res_do_q <= res_do;
        end
    end

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        lprime_d = lprime_q;
        rdv_d    = rdv_q;
        pix_d    = pix_q;
        wa_d     = wa_q;
        bc_d     = bc_q;
        sh_d     = sh_q;
        nb_d     = nb_q;
        min_d    = min_q;
        self_d   = self_q;
        ag_init  = 1'b0;
        ag_fwd   = 1'b0;
        ag_bwd   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_LOAD;
                    mode_d   = mode;
                    lprime_d = 1'b1;
                    pix_d    = '0;
                    wa_d     = '0;
                    bc_d     = '0;
                end
            end
            S_LOAD: begin
                if (lprime_q) begin
                    lprime_d = 1'b0;
                    wa_d     = wa_q + SA_W'(1);
                end else begin
                    sh_d = cur_word << 1;
                    bc_d = (bc_q == BC_LAST) ? '0 : bc_q + BC_W'(1);
                    if (bc_q == BC_LAST && pix_q != PIX_LAST)
                        wa_d = wa_q + SA_W'(1);
                    if (pix_q == PIX_LAST) begin
                        state_d = S_FWD_RD;
                        ag_init = 1'b1;
                        rdv_d   = 1'b0;
                    end else begin
                        pix_d = pix_q + RA_W'(1);
                    end
                end
            end
            S_FWD_RD: begin
                rdv_d = ~rdv_q;
                if (rdv_q) begin
                    if (res_di != '0) begin
                        state_d = S_FWD_NB;
                        nb_d    = '0;
                    end else if (ag_last) begin
                        state_d = S_BWD_RD;
                    end else begin
                        ag_fwd = 1'b1;
                    end
                end
            end
            S_FWD_NB, S_BWD_NB: begin
                // Each cycle folds in the neighbour requested on the previous cycle.
                min_d = (nb_q == 2'd0) ? '1 : nb_min;
                nb_d  = nb_q + 2'd1;
                if (nb_q == nb_last)
                    state_d = (state_q == S_FWD_NB) ? S_FWD_WR : S_BWD_WR;
            end
            S_FWD_WR: begin
                if (ag_last) begin
                    state_d = S_BWD_RD;
                end else begin
                    ag_fwd  = 1'b1;
                    state_d = S_FWD_RD;
                end
            end
            S_BWD_RD: begin
                rdv_d = ~rdv_q;
                if (rdv_q) begin
                    self_d = res_di;
                    if (res_di != '0) begin
                        state_d = S_BWD_NB;
                        nb_d    = '0;
                    end else if (ag_first) begin
                        state_d = S_FIN;
                    end else begin
                        ag_bwd = 1'b1;
                    end
                end
            end
            S_BWD_WR: begin
                if (ag_first) begin
                    state_d = S_FIN;
                end else begin
                    ag_bwd  = 1'b1;
                    state_d = S_BWD_RD;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy     = (state_q != S_IDLE) && (state_q != S_FIN);
        done     = (state_q == S_FIN);
        sti_rd   = 1'b0;
        sti_addr = '0;
        res_rd   = 1'b0;
        res_wr   = 1'b0;
        res_addr = '0;
        res_do   = res_do_q;
        case (state_q)
            S_LOAD: begin
                res_addr = pix_q;
                if (lprime_q) begin
                    sti_rd   = 1'b1;
                    sti_addr = wa_q;
                end else begin
                    res_wr = 1'b1;
                    res_do = DIST_W'(cur_word[WORD_W-1]);
                    if (bc_q == BC_LAST && pix_q != PIX_LAST) begin
                        sti_rd   = 1'b1;
                        sti_addr = wa_q;
                    end
                end
            end
            S_FWD_RD, S_BWD_RD: begin
                res_addr = ag_addr;
                res_rd   = ~rdv_q;
            end
            S_FWD_NB, S_BWD_NB: begin
                res_addr = ag_addr;
                res_rd   = 1'b1;
            end
            S_FWD_WR: begin
                res_addr = ag_addr;
                res_wr   = 1'b1;
                res_do   = fwd_val;
            end
            S_BWD_WR: begin
                res_addr = ag_addr;
                res_wr   = 1'b1;
                res_do   = bwd_val;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/dt_param.md
Name: dt_param

Overview:
- Parametrised two-pass chamfer distance-transform engine, successor to the fixed 128x128 DT block.
- Streams a packed binary image from the sti ROM, expands it into one pixel per word in the res RAM, then runs a forward raster pass and a backward raster pass in place.
- Adds a start/busy/done handshake, a selectable metric (chessboard or city-block), saturating distances and generic image/word/distance widths.
- Sits between the stimulus ROM and the result RAM in the DT test harness.

Parameters:
- IMG_W, 128, image width in pixels; multiple of WORD_W, >=3
- IMG_H, 128, image height in pixels; >=3
- WORD_W, 16, pixels per sti word
- DIST_W, 8, bits per res pixel; distance saturates at 2^DIST_W-1
- Localparams: NPIX=IMG_W*IMG_H; RA_W=clog2(NPIX); SA_W=clog2(NPIX/WORD_W)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- mode  in  1  0=chessboard (8-neighbour), 1=city-block (4-neighbour); latched on start
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse when the backward pass is complete
- sti_rd  out  1  ROM read strobe
- sti_addr  out  SA_W  ROM word address
- sti_di  in  WORD_W  ROM data; valid the cycle after sti_rd
- res_rd  out  1  RAM read strobe
- res_wr  out  1  RAM write strobe
- res_addr  out  RA_W  RAM pixel address = row*IMG_W+col
- res_do  out  DIST_W  RAM write data
- res_di  in  DIST_W  RAM read data; valid the cycle after res_rd

Behaviour:
- Decided interface: one clock clk; reset is asynchronous and active-low.
- Reset: all outputs 0, FSM in IDLE. Reset asserted mid-operation aborts immediately; RAM contents are then undefined and done is not pulsed.
- FSM states: IDLE -> LOAD -> FWD_RD -> FWD_NB -> FWD_WR -> BWD_RD -> BWD_NB -> BWD_WR -> FIN -> IDLE.
- IDLE:
  - start=1 latches mode and enters LOAD.
  - start while busy=1 is ignored; it has no effect on the operation in progress.
- LOAD:
  - Read words 0..NPIX/WORD_W-1 in order.
  - Bit WORD_W-1 of each word is the leftmost pixel.
  - Write 0 or 1 to res_addr 0..NPIX-1 in order, one pixel per cycle, with res_wr=1.
  - sti reads are pipelined so there is no bubble between words.
- Border ring (row 0, row IMG_H-1, col 0, col IMG_W-1):
  - The stimulus guarantees it is background.
  - Both passes visit only interior pixels and never rewrite the border.
- Forward pass (FWD_RD -> FWD_NB -> FWD_WR), raster order over the interior:
  - FWD_RD reads the pixel; a value of 0 stays in FWD_RD and advances to the next pixel.
  - A nonzero value enters FWD_NB, which reads the neighbours NW, N, NE, W (chessboard) or N, W (city-block), one per cycle.
  - FWD_WR writes min(neighbours)+1.
- Backward pass (BWD_RD -> BWD_NB -> BWD_WR), reverse raster order over the interior:
  - BWD_NB reads E, SW, S, SE (chessboard) or E, S (city-block).
  - BWD_WR writes min(self, min(neighbours)+1).
- Arithmetic:
  - +1 is computed in DIST_W+1 bits and clamped to 2^DIST_W-1.
  - min is unsigned.
  - Address offsets are computed modulo 2^RA_W; no wrap occurs for interior pixels.
- Pass transitions:
  - After the last interior pixel of the forward pass (IMG_H-2, IMG_W-2): go to BWD_RD at that same pixel.
  - After pixel (1,1) of the backward pass: go to FIN.
- FIN:
  - done=1 and busy=0 in the same cycle.
  - Return to IDLE the next cycle.
- Strobes: res_rd and res_wr are never high together. res_do is held at its last value when res_wr=0.

Decomposition:
- Package dt_pkg holds:
  - the state enum;
  - the neighbour-offset constants (NW=-IMG_W-1, N=-IMG_W, NE=-IMG_W+1, W=-1, mirrored for the backward pass);
  - the neighbour-count function of mode;
  - the saturating-increment function.
- One natural sub-module, dt_addr_gen: holds the row/col counters and produces res_addr for the current pixel plus neighbour index in the current direction, and the first/last-interior flags.

Test Plan:
- 8x8, DIST_W=8, mode=0, all interior object -> (1,1)=1, (2,2)=2, (3,3)=3, (3,4)=3; border 0; done pulses exactly once.
- 8x8, mode=0 vs mode=1, all interior object except background at (3,3) -> (2,2)=1 in chessboard, (2,2)=2 in city-block; (1,1)=1 in both.
- 16x16, DIST_W=2, mode=1, all interior object -> (7,7)=3 (saturated; true 7); no value exceeds 3.
- 128x128 defaults, single object pixel at (64,64) -> res(64*128+64)=1; all other pixels 0; busy high from start+1 until done.
- start pulsed again mid-forward-pass -> ignored; final image identical to an undisturbed run; single done pulse.
- reset asserted mid-backward-pass -> all outputs 0 next edge; a new start runs to completion with correct results.
